seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
Parametrised multiplexed 7-segment display driver. It holds a double-buffered BCD frame and time-multiplexes DISPLAYS_NUM digits onto a shared segment bus. It adds features the current BCD mux lacks: integrated segment decode, decimal points, leading-zero blanking, PWM brightness, tear-free frame updates and configurable output polarity. It sits between the register/counter logic that produces BCD values and the board's display pins.

Parameters:
DISPLAYS_NUM, 4, number of digits; must be >= 2.
SCAN_CLK_COUNT, 10, clock cycles per digit slot; must be >= 2.
BRIGHT_W, 4, width of the brightness input.
SEL_ACTIVE_LOW, 0, 1 inverts o_sel.
SEG_ACTIVE_LOW, 0, 1 inverts o_seg and o_dp.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset, synchronous, active-high.
i_bcd_data  in  DISPLAYS_NUM*4  digit k in bits [4k+3:4k]; digit 0 is least significant (rightmost).
i_dp  in  DISPLAYS_NUM  decimal point per digit; bit k belongs to digit k.
i_load  in  1  one-cycle strobe that captures i_bcd_data and i_dp into the shadow buffer.
i_blank_lz  in  1  enables leading-zero blanking.
i_bright  in  BRIGHT_W  on-cycles per slot.
o_seg  out  7  segments {g,f,e,d,c,b,a}.
o_dp  out  1  decimal point.
o_sel  out  DISPLAYS_NUM  one-hot digit select, or all inactive.
o_digit_idx  out  clogb2(DISPLAYS_NUM)  index of the digit currently driven.
o_frame_start  out  1  one-cycle pulse when a new frame begins.

Behaviour:
- Reset is synchronous and active-high on i_rst. On reset:
  - counters, shadow and active buffers, pending flag and latched brightness all clear to 0.
  - o_sel and o_seg/o_dp go to their inactive level (all 0, or all 1 when the matching ACTIVE_LOW parameter is 1).
  - o_digit_idx = 0 and o_frame_start = 0.
  - Reset mid-frame discards any pending load.
- Slot counter:
  - Runs 0..SCAN_CLK_COUNT-1 and wraps.
  - At slot end, the digit index increments; it wraps from DISPLAYS_NUM-1 to 0.
- Frame boundary is the slot end with index = DISPLAYS_NUM-1. At the boundary:
  - if the pending flag is set, active buffer <= shadow and pending is cleared;
  - bright_lat <= i_bright and blank_lat <= i_blank_lz.
- Load handling:
  - i_load writes the shadow buffer and sets pending.
  - If i_load coincides with a boundary, the shadow is written but pending stays set; the transfer to the active buffer happens at the next boundary.
  - A second load before the boundary overwrites the shadow; the last load wins.
- Brightness:
  - on_cycles = min(bright_lat, SCAN_CLK_COUNT).
  - The select is asserted while slot_cnt < on_cycles.
  - bright_lat = 0 means the display is dark, but scanning continues.
- Decode, gfedcba, active-high form:
  - digits 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - nibbles A..F: 40 (dash, error glyph).
- Leading-zero blanking:
  - When blank_lat = 1, digit k (k > 0) is blanked if it and every more-significant digit are 0.
  - A blanked digit drives o_seg = 0x00; its DP is still honoured.
  - Digit 0 is never blanked.
- Output timing:
  - o_seg, o_dp, o_sel, o_digit_idx and o_frame_start are registered.
  - They are valid one cycle after the counter state they reflect and stay mutually aligned.
  - The first post-reset slot drives digit 0.
- o_frame_start pulses in the same output cycle that the first slot of the new frame (digit 0) appears.

Decomposition:
- Package seg7_pkg: clogb2 function, the segment constants SEG_0..SEG_9 and SEG_DASH, and the SEG_BLANK constant.
- Sub-module seg7_decoder: combinational, 4-bit value plus blank input -> 7-bit pattern.
- Counters, buffers, brightness and output registers stay in seg7_scan_mux.

Test Plan:
Default parameters unless stated; cycle 0 is the first cycle after reset release.
- Reset, then i_bright = 10, no load -> o_sel steps 0001, 0010, 0100, 1000 at 10 cycles each after the first boundary latches brightness; each digit shows o_seg = 0x3F; o_frame_start pulses every 40 cycles.
- i_load with data 0x1234 and i_dp = 0010 at cycle 15:
  - display is unchanged until the boundary at cycle 39;
  - next frame shows digit0 = 0x66, digit1 = 0x4F with o_dp = 1, digit2 = 0x5B, digit3 = 0x06.
- i_load at exactly cycle 39 (the boundary) -> old data is shown for one more full frame; new data appears at cycle 80.
- Leading-zero blanking, i_blank_lz = 1:
  - data 0x0040 -> digits 3 and 2 show 0x00, digit1 0x66, digit0 0x3F;
  - data 0x0000 -> only digit0 lit (0x3F);
  - data 0x0B07 -> digit2 shows 0x40.
- Brightness:
  - i_bright = 3 -> o_sel active 3 of every 10 cycles;
  - i_bright = 0 -> o_sel never active, but o_digit_idx keeps advancing;
  - i_bright = 15 -> o_sel active for all 10 cycles;
  - SEL_ACTIVE_LOW = 1 -> same sequence with o_sel inverted.
- i_rst asserted at cycle 23 with a load pending -> at the next edge all outputs are at their reset level; after release, digit 0 shows 0x3F and the pending data is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-high segment pattern; non-decimal nibbles show a dash.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Glyph lookup with blanking override
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_value)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with double-buffered frames, leading-zero
// blanking, PWM brightness and configurable output polarity.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DISPLAYS_NUM   = 4,
    parameter int SCAN_CLK_COUNT = 10,
    parameter int BRIGHT_W       = 4,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [DISPLAYS_NUM*4-1:0]        i_bcd_data,
    input  logic [DISPLAYS_NUM-1:0]          i_dp,
    input  logic                             i_load,
    input  logic                             i_blank_lz,
    input  logic [BRIGHT_W-1:0]              i_bright,
    output logic [6:0]                       o_seg,
    output logic                             o_dp,
    output logic [DISPLAYS_NUM-1:0]          o_sel,
    output logic [clogb2(DISPLAYS_NUM)-1:0]  o_digit_idx,
    output logic                             o_frame_start
);

    localparam int IDX_W = clogb2(DISPLAYS_NUM);
    localparam int CNT_W = clogb2(SCAN_CLK_COUNT);

    localparam logic [DISPLAYS_NUM-1:0] SEL_OFF =
        (SEL_ACTIVE_LOW != 0) ? {DISPLAYS_NUM{1'b1}} : {DISPLAYS_NUM{1'b0}};
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0]          r_slot_cnt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [DISPLAYS_NUM*4-1:0] r_shadow_bcd;
    logic [DISPLAYS_NUM*4-1:0] r_active_bcd;
    logic [DISPLAYS_NUM-1:0]   r_shadow_dp;
    logic [DISPLAYS_NUM-1:0]   r_active_dp;
    logic                      r_pending;
    logic [BRIGHT_W-1:0]       r_bright_lat;
    logic                      r_blank_lat;

    logic                      w_slot_end;
    logic                      w_boundary;
    logic [31:0]               w_on_cycles;
    logic                      w_sel_on;
    logic [DISPLAYS_NUM-1:0]   w_sel_onehot;
    logic [DISPLAYS_NUM-1:0]   w_lz_mask;
    logic [3:0]                w_cur_nib;
    logic                      w_cur_blank;
    logic [6:0]                w_dec_seg;

    assign w_slot_end   = (r_slot_cnt == CNT_W'(SCAN_CLK_COUNT - 1));
    assign w_boundary   = w_slot_end && (r_digit_idx == IDX_W'(DISPLAYS_NUM - 1));
    assign w_on_cycles  = (32'(r_bright_lat) > 32'(SCAN_CLK_COUNT)) ?
                          32'(SCAN_CLK_COUNT) : 32'(r_bright_lat);
    assign w_sel_on     = (32'(r_slot_cnt) < w_on_cycles);
    assign w_sel_onehot = {{(DISPLAYS_NUM-1){1'b0}}, 1'b1} << r_digit_idx;
    assign w_cur_nib    = r_active_bcd[{r_digit_idx, 2'b00} +: 4];
    assign w_cur_blank  = w_lz_mask[r_digit_idx];

    // Digit k blanks only when it and every more-significant digit are zero
    always_comb begin
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_lz_mask  = {DISPLAYS_NUM{1'b0}};
        for (int k = DISPLAYS_NUM - 1; k > 0; k--) begin
            w_zero_run   = w_zero_run & (r_active_bcd[4*k +: 4] == 4'd0);
            w_lz_mask[k] = r_blank_lat & w_zero_run;
        end
    end

    seg7_decoder u_decoder (
        .i_value (w_cur_nib),
        .i_blank (w_cur_blank),
        .o_seg   (w_dec_seg)
    );

    // Slot and digit scan counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot_cnt  <= {CNT_W{1'b0}};
            r_digit_idx <= {IDX_W{1'b0}};
        end else if (w_slot_end) begin
            r_slot_cnt  <= {CNT_W{1'b0}};
            r_digit_idx <= (r_digit_idx == IDX_W'(DISPLAYS_NUM - 1)) ?
                           {IDX_W{1'b0}} : r_digit_idx + IDX_W'(1);
        end else begin
            r_slot_cnt  <= r_slot_cnt + CNT_W'(1);
        end
    end

    // Shadow/active frame buffers; a load on the boundary is held for the next frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow_bcd <= {(DISPLAYS_NUM*4){1'b0}};
            r_active_bcd <= {(DISPLAYS_NUM*4){1'b0}};
            r_shadow_dp  <= {DISPLAYS_NUM{1'b0}};
            r_active_dp  <= {DISPLAYS_NUM{1'b0}};
            r_pending    <= 1'b0;
            r_bright_lat <= {BRIGHT_W{1'b0}};
            r_blank_lat  <= 1'b0;
        end else begin
            if (w_boundary) begin
                if (r_pending) begin
                    r_active_bcd <= r_shadow_bcd;
                    r_active_dp  <= r_shadow_dp;
                end
                r_bright_lat <= i_bright;
                r_blank_lat  <= i_blank_lz;
            end
            if (i_load) begin
                r_shadow_bcd <= i_bcd_data;
                r_shadow_dp  <= i_dp;
                r_pending    <= 1'b1;
            end else if (w_boundary) begin
                r_pending    <= 1'b0;
            end
        end
    end

    // Registered, polarity-adjusted outputs aligned to the counter state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sel         <= SEL_OFF;
            o_seg         <= SEG_OFF;
            o_dp          <= DP_OFF;
            o_digit_idx   <= {IDX_W{1'b0}};
            o_frame_start <= 1'b0;
        end else begin
            o_sel         <= (w_sel_on ? w_sel_onehot : {DISPLAYS_NUM{1'b0}}) ^ SEL_OFF;
            o_seg         <= w_dec_seg ^ SEG_OFF;
            o_dp          <= r_active_dp[r_digit_idx] ^ DP_OFF;
            o_digit_idx   <= r_digit_idx;
            o_frame_start <= (r_slot_cnt == {CNT_W{1'b0}}) && (r_digit_idx == {IDX_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a frame-level reference model queues the
// expected outputs each cycle; a monitor checks two DUTs of opposite polarity.
module tb_seg7_scan_mux;

    localparam int N    = 4;
    localparam int SCAN = 10;
    localparam int P    = N * SCAN;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] sel;
        logic [1:0]   idx;
        logic         fs;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [15:0]  bcd;
    logic [3:0]   dpi;
    logic         load;
    logic         blank;
    logic [3:0]   bright;

    logic [6:0]   seg0, seg1;
    logic         dp0, dp1;
    logic [3:0]   sel0, sel1;
    logic [1:0]   idx0, idx1;
    logic         fs0, fs1;

    exp_t         sb_q[$];
    int           n_cmp;
    int           n_err;

    int           m_cyc;
    int           m_bright;
    logic         m_blank;
    logic [15:0]  m_frame_bcd;
    logic [3:0]   m_frame_dp;
    logic         m_has_load;
    logic [15:0]  m_load_bcd;
    logic [3:0]   m_load_dp;

    seg7_scan_mux #(.DISPLAYS_NUM(N), .SCAN_CLK_COUNT(SCAN), .BRIGHT_W(4),
                    .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut_hi (
        .i_clk(clk), .i_rst(rst), .i_bcd_data(bcd), .i_dp(dpi), .i_load(load),
        .i_blank_lz(blank), .i_bright(bright), .o_seg(seg0), .o_dp(dp0),
        .o_sel(sel0), .o_digit_idx(idx0), .o_frame_start(fs0));

    seg7_scan_mux #(.DISPLAYS_NUM(N), .SCAN_CLK_COUNT(SCAN), .BRIGHT_W(4),
                    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_lo (
        .i_clk(clk), .i_rst(rst), .i_bcd_data(bcd), .i_dp(dpi), .i_load(load),
        .i_blank_lz(blank), .i_bright(bright), .o_seg(seg1), .o_dp(dp1),
        .o_sel(sel1), .o_digit_idx(idx1), .o_frame_start(fs1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected output for the current cycle, then advance the frame-level model
    task automatic model_cycle();
        exp_t e;
        int   slot;
        int   digit;
        int   on;
        logic blanked;
        if (rst) begin
            e           = '{seg: 7'h00, dp: 1'b0, sel: 4'h0, idx: 2'd0, fs: 1'b0};
            m_cyc       = 0;
            m_bright    = 0;
            m_blank     = 1'b0;
            m_frame_bcd = 16'h0000;
            m_frame_dp  = 4'h0;
            m_has_load  = 1'b0;
        end else begin
            slot    = m_cyc % SCAN;
            digit   = (m_cyc / SCAN) % N;
            on      = (m_bright < SCAN) ? m_bright : SCAN;
            blanked = m_blank && (digit > 0) && ((m_frame_bcd >> (4 * digit)) == 16'h0000);
            e.seg   = blanked ? 7'h00 : glyph(m_frame_bcd[4*digit +: 4]);
            e.dp    = m_frame_dp[digit];
            e.sel   = (slot < on) ? (4'b0001 << digit) : 4'b0000;
            e.idx   = 2'(digit);
            e.fs    = ((m_cyc % P) == 0);
            if ((m_cyc % P) == P - 1) begin
                if (m_has_load) begin
                    m_frame_bcd = m_load_bcd;
                    m_frame_dp  = m_load_dp;
                    m_has_load  = 1'b0;
                end
                m_bright = int'(bright);
                m_blank  = blank;
            end
            if (load) begin
                m_load_bcd = bcd;
                m_load_dp  = dpi;
                m_has_load = 1'b1;
            end
            m_cyc++;
        end
        sb_q.push_back(e);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic run_to(input int c);
        for (int k = 0; k < 400 && m_cyc < c; k++) step();
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bcd  = d;
        dpi  = p;
        load = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; step();
        rst = 1'b1; step();
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] d;
        for (int k = 0; k < 4; k++) begin
            d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    // Monitor: pop one expectation per output cycle and check both polarities
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({seg0, dp0, sel0, idx0, fs0} !== e) begin
                    n_err++;
                    $display("FAIL out_hi t=%0t got seg=%h dp=%b sel=%b idx=%0d fs=%b want seg=%h dp=%b sel=%b idx=%0d fs=%b",
                             $time, seg0, dp0, sel0, idx0, fs0, e.seg, e.dp, e.sel, e.idx, e.fs);
                end
                n_cmp++;
                if ({seg1, dp1, sel1, idx1, fs1} !== {~e.seg, ~e.dp, ~e.sel, e.idx, e.fs}) begin
                    n_err++;
                    $display("FAIL out_lo t=%0t got seg=%h dp=%b sel=%b idx=%0d fs=%b want seg=%h dp=%b sel=%b idx=%0d fs=%b",
                             $time, seg1, dp1, sel1, idx1, fs1, ~e.seg, ~e.dp, ~e.sel, e.idx, e.fs);
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_cyc  = 0;
        rst    = 1'b1;
        bcd    = 16'h0000;
        dpi    = 4'h0;
        load   = 1'b0;
        blank  = 1'b0;
        bright = 4'd10;
        do_reset();

        // Load mid-frame, then a load exactly on the boundary
        run_to(15);
        do_load(16'h1234, 4'b0010);
        run_to(39);
        do_load(16'h5678, 4'b1001);
        run_to(3 * P);

        // Brightness sweep
        bright = 4'd3;  run_n(2 * P);
        bright = 4'd0;  run_n(2 * P);
        bright = 4'd15; run_n(2 * P);

        // Leading-zero blanking patterns
        blank = 1'b1;
        do_load(16'h0040, 4'b0100); run_n(2 * P);
        do_load(16'h0000, 4'b0000); run_n(2 * P);
        do_load(16'h0B07, 4'b0000); run_n(2 * P);
        blank = 1'b0;

        // Reset while a load is pending
        do_reset();
        run_to(15);
        do_load(16'h9876, 4'b1111);
        run_to(23);
        rst = 1'b1; step();
        run_n(2 * P);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (($urandom_range(0, 29) == 0) ||
                ((m_cyc % P) == P - 1 && $urandom_range(0, 3) == 0)) begin
                bcd  = rand_bcd();
                dpi  = 4'($urandom_range(0, 15));
                load = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) blank = ~blank;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain got %0d pending expectations want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
